// File: rtl/xbar_output_arbiter_if.sv
// Handshake bundle between NUM_IN crossbar inputs and one output port.
interface xbar_output_arbiter_if #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_last;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic                     out_ready;

  // Upstream sources plus downstream sink, i.e. everything around the arbiter.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The arbiter itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/xbar_output_arbiter.sv
// Packet-granular round-robin arbiter for one crossbar output port.
// A winner is locked from its first beat until its last beat transfers,
// then one IDLE cycle separates it from the next packet.
module xbar_output_arbiter #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  xbar_output_arbiter_if.slave bus,
  output logic [NUM_IN-1:0]    grant,
  output logic                 busy,
  output logic [15:0]          pkt_count
);

  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  g_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [15:0]       pkt_cnt_q;

  logic              found;
  logic [IDX_W-1:0]  win_idx;
  logic [NUM_IN-1:0] win_oh;
  int unsigned       cand;
  logic              out_fire;

  assign pkt_count = pkt_cnt_q;

  // Round-robin search starting one past the last packet's owner, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_IN;
      if (!found && bus.in_valid[IDX_W'(cand)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
    win_oh = NUM_IN'(1) << win_idx;
  end

  // Output-port mux driven from the registered grant index; quiet in IDLE.
  always_comb begin
    bus.in_ready  = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    if (state == LOCKED) begin
      bus.out_valid        = bus.in_valid[g_idx];
      bus.out_last         = bus.in_last[g_idx];
      bus.out_data         = bus.in_data[32'(g_idx)*DATA_W +: DATA_W];
      bus.in_ready[g_idx]  = bus.out_ready;
    end
  end

  assign out_fire = (state == LOCKED) && bus.in_valid[g_idx] && bus.out_ready;

  // Arbitration FSM: lock on a request, release after the last beat transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      g_idx     <= '0;
      rr_ptr    <= IDX_W'(NUM_IN - 1);
      busy      <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= LOCKED;
            grant <= win_oh;
            g_idx <= win_idx;
            busy  <= 1'b1;
          end
        end
        LOCKED: begin
          if (out_fire && bus.in_last[g_idx]) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            rr_ptr    <= g_idx;
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_output_arbiter.sv
// Directed bench for xbar_output_arbiter: cycle table plus streaming and wrap sequences.
module tb_xbar_output_arbiter;

  localparam int unsigned NUM_IN = 4;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [NUM_IN-1:0] grant;
  logic              busy;
  logic [15:0]       pkt_count;
  logic [31:0]       dval [NUM_IN];

  int checks = 0;
  int errors = 0;

  xbar_output_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) bus ();

  xbar_output_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-input payload words packed onto the flat data bus.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*DATA_W +: DATA_W] = dval[i];
  end

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [3:0]  il;
    logic        ordy;
    logic [31:0] d;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_ov;
    logic [3:0]  e_ir;
    logic        e_ol;
    logic [31:0] e_od;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] iv, logic [3:0] il, logic ordy,
                              logic [31:0] d, logic [3:0] eg, logic eb, logic eov,
                              logic [3:0] eir, logic eol, logic [31:0] eod, logic [15:0] epc);
    vec_t v;
    v.rst = r; v.iv = iv; v.il = il; v.ordy = ordy; v.d = d;
    v.e_grant = eg; v.e_busy = eb; v.e_ov = eov; v.e_ir = eir;
    v.e_ol = eol; v.e_od = eod; v.e_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) dval[i] = 32'(i) << 28;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Streaming state for four inputs each sending 3-beat packets.
  int          bcnt [NUM_IN];
  int          pcnt [NUM_IN];
  logic [3:0]  fire;
  logic [3:0]  prev_grant;
  int          nb;
  int          ng;
  logic [31:0] exp_d;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Single-beat packets from inputs 1 and 3, reset priority over requests.
    vecs.push_back(mk(1, 4'b1010, 4'b1010, 1, 32'h11, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd0));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 32'h12, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd0));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 32'h13, 4'b0010, 1, 1, 4'b0010, 1, 32'h1000_0013, 16'd0));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 32'h14, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd1));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 32'h15, 4'b1000, 1, 1, 4'b1000, 1, 32'h3000_0015, 16'd1));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 32'h16, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd2));
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 32'h17, 4'b0010, 1, 1, 4'b0010, 1, 32'h1000_0017, 16'd2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h18, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h19, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd3));
    // Downstream stall for three cycles on a 2-beat packet from input 0.
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 32'h20, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd3));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 32'h21, 4'b0001, 1, 1, 4'b0000, 0, 32'h21, 16'd3));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 32'h21, 4'b0001, 1, 1, 4'b0000, 0, 32'h21, 16'd3));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 32'h21, 4'b0001, 1, 1, 4'b0000, 0, 32'h21, 16'd3));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 32'h21, 4'b0001, 1, 1, 4'b0001, 0, 32'h21, 16'd3));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 32'h22, 4'b0001, 1, 1, 4'b0001, 1, 32'h22, 16'd3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h23, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd4));
    // Input 2 drops valid mid-packet while input 0 waits.
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 32'h30, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd4));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 32'h31, 4'b0100, 1, 1, 4'b0100, 0, 32'h2000_0031, 16'd4));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 32'h32, 4'b0100, 1, 1, 4'b0100, 0, 32'h2000_0032, 16'd4));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 32'h33, 4'b0100, 1, 0, 4'b0100, 0, 32'h0, 16'd4));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 32'h33, 4'b0100, 1, 0, 4'b0100, 0, 32'h0, 16'd4));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 32'h34, 4'b0100, 1, 1, 4'b0100, 0, 32'h2000_0034, 16'd4));
    vecs.push_back(mk(0, 4'b0101, 4'b0100, 1, 32'h35, 4'b0100, 1, 1, 4'b0100, 1, 32'h2000_0035, 16'd4));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 32'h36, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd5));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 32'h37, 4'b0001, 1, 1, 4'b0001, 1, 32'h37, 16'd5));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h38, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd6));
    // Reset on beat 2 of a 4-beat packet from input 1, then 1 beats 3.
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 32'h40, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd6));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 32'h41, 4'b0010, 1, 1, 4'b0010, 0, 32'h1000_0041, 16'd6));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 1, 32'h42, 4'b0010, 1, 1, 4'b0010, 0, 32'h1000_0042, 16'd6));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 1, 32'h43, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd0));
    vecs.push_back(mk(0, 4'b1010, 4'b0010, 1, 32'h44, 4'b0010, 1, 1, 4'b0010, 1, 32'h1000_0044, 16'd0));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 1, 32'h45, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd1));
    vecs.push_back(mk(0, 4'b1010, 4'b1000, 1, 32'h46, 4'b1000, 1, 1, 4'b1000, 1, 32'h3000_0046, 16'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'h47, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 16'd2));

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.in_valid  = vecs[i].iv;
      bus.in_last   = vecs[i].il;
      bus.out_ready = vecs[i].ordy;
      for (int j = 0; j < NUM_IN; j++) dval[j] = vecs[i].d | (32'(j) << 28);
      @(negedge clk);
      check($sformatf("v%0d grant", i), 64'(grant), 64'(vecs[i].e_grant));
      check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_ov));
      check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_ir));
      check($sformatf("v%0d pkt_count", i), 64'(pkt_count), 64'(vecs[i].e_pc));
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d out_data", i), 64'(bus.out_data), 64'(vecs[i].e_od));
        check($sformatf("v%0d out_last", i), 64'(bus.out_last), 64'(vecs[i].e_ol));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // All four inputs stream 3-beat packets: expect grants 0,1,2,3,0 and no interleaving.
    do_reset();
    for (int i = 0; i < NUM_IN; i++) begin bcnt[i] = 0; pcnt[i] = 0; end
    prev_grant = '0;
    nb = 0;
    ng = 0;
    for (int cyc = 0; cyc < 40 && nb < 15; cyc++) begin
      bus.in_valid  = 4'hF;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
        bus.in_last[i] = (bcnt[i] == 2);
        dval[i] = {4'(i), 4'h0, 8'(pcnt[i]), 16'(bcnt[i])};
      end
      @(negedge clk);
      if (grant != 4'b0000 && prev_grant == 4'b0000 && ng < 5) begin
        check($sformatf("stream grant %0d", ng), 64'(grant), 64'(4'b0001 << (ng % 4)));
        ng++;
      end
      prev_grant = grant;
      if (bus.out_valid && bus.out_ready) begin
        exp_d = {4'(((nb / 3) % 4)), 4'h0, 8'((nb / 3) / 4), 16'(nb % 3)};
        check($sformatf("stream beat %0d data", nb), 64'(bus.out_data), 64'(exp_d));
        check($sformatf("stream beat %0d last", nb), 64'(bus.out_last), 64'((nb % 3) == 2));
        nb++;
      end
      fire = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (fire[i]) begin
          if (bcnt[i] == 2) begin bcnt[i] = 0; pcnt[i] = pcnt[i] + 1; end
          else bcnt[i] = bcnt[i] + 1;
        end
      end
    end
    check("stream beats within budget", 64'(nb), 64'd15);
    check("stream grants within budget", 64'(ng), 64'd5);

    // Packet counter wraps from 0xFFFF to 0x0000.
    do_reset();
    force dut.pkt_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.pkt_cnt_q;
    @(negedge clk);
    check("wrap preload", 64'(pkt_count), 64'hFFFF);
    bus.in_valid = 4'b0001;
    bus.in_last  = 4'b0001;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wrap grant", 64'(grant), 64'b0001);
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    bus.in_last  = '0;
    @(negedge clk);
    check("wrap pkt_count", 64'(pkt_count), 64'h0000);
    check("wrap busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbar_output_arbiter.md
XBAR_OUTPUT_ARBITER -- requirements
Module: xbar_output_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4: number of crossbar input ports competing for this output port (2..16).
REQ-002 Parameter DATA_W, default 32: payload width per port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  NUM_IN  per-input valid; bit i belongs to input i.
REQ-006 in_data  input  NUM_IN*DATA_W  per-input payload; input i occupies bits [i*DATA_W +: DATA_W].
REQ-007 in_last  input  NUM_IN  per-input end-of-packet marker, qualified by in_valid.
REQ-008 in_ready  output  NUM_IN  per-input ready.
REQ-009 out_valid  output  1  output-port valid.
REQ-010 out_data  output  DATA_W  output-port payload.
REQ-011 out_last  output  1  output-port end-of-packet.
REQ-012 out_ready  input  1  downstream ready.
REQ-013 grant  output  NUM_IN  registered one-hot grant; all zero when no input is granted.
REQ-014 busy  output  1  high while in LOCKED.
REQ-015 pkt_count  output  16  number of completed packets, wrapping at 16 bits.

Function
REQ-016 Transfer on any port = valid & ready in the same cycle; a beat is moved only on a transfer.
REQ-017 FSM has two states: IDLE and LOCKED.
REQ-018 IDLE: grant = 0, out_valid = 0, in_ready = all 0; no beat is accepted.
REQ-019 IDLE, any in_valid set: next cycle enters LOCKED, grant = one-hot of the winner.
REQ-020 Winner = first requesting input at or after index (rr_ptr+1) mod NUM_IN, searching upward with wrap.
REQ-021 IDLE, no in_valid set: remain in IDLE.
REQ-022 Arbitration latency is exactly 1 cycle, from a request seen in IDLE to grant asserted.
REQ-023 LOCKED, grant index g: out_valid = in_valid[g], out_data = in_data[g], out_last = in_last[g], in_ready[g] = out_ready, all other in_ready = 0; these are combinational from the registered grant.
REQ-024 LOCKED holds g for the whole packet; in_valid[g] deasserting mid-packet does not release the lock, and out_valid follows it low.
REQ-025 Transfer with out_last = 1 in LOCKED: next cycle IDLE, grant = 0, rr_ptr = g, pkt_count += 1.
REQ-026 There is exactly one IDLE bubble cycle between packets, including back-to-back requests from the same or another input.
REQ-027 A single-beat packet (last on the first beat) follows REQ-025; LOCKED lasts one cycle if out_ready = 1.
REQ-028 Requests arriving on non-granted inputs during LOCKED are ignored until the next IDLE.
REQ-029 out_data is don't-care when out_valid = 0 but must not be X from non-granted inputs.
REQ-030 pkt_count wraps from 0xFFFF to 0x0000.

Reset
REQ-031 rst = 1 at a clock edge: state = IDLE, grant = 0, rr_ptr = NUM_IN-1 (input 0 has first priority), pkt_count = 0.
REQ-032 rst during LOCKED aborts the packet; no in_ready is asserted in the cycle after the reset edge.
REQ-033 Outputs after reset: busy = 0, out_valid = 0, out_last = 0, in_ready = 0.
REQ-034 rst has priority over every other event in the same cycle.

Verification
REQ-035 After reset, in_valid = 4'b1010, single-beat packets, out_ready = 1 -> grants in order 0010, 1000, 0010; one IDLE cycle between grants; pkt_count = 3.
REQ-036 All four inputs send 3-beat packets continuously -> grant order 0001, 0010, 0100, 1000, 0001; out_data beats are never interleaved between inputs.
REQ-037 Input 2 granted, in_valid[2] low for 2 cycles mid-packet while in_valid[0] = 1 -> grant stays 0100 and out_valid = 0 for those cycles; input 0 is granted only after input 2's last beat.
REQ-038 out_ready = 0 for 3 cycles during LOCKED -> in_ready[g] = 0 for those cycles; out_data stable; no beat lost or duplicated.
REQ-039 rst pulsed during beat 2 of a 4-beat packet from input 1 -> next cycle grant = 0, busy = 0, pkt_count = 0; a later request on input 1 wins before input 3 when both are pending.
REQ-040 Drive pkt_count to 0xFFFF, complete one packet -> pkt_count = 0x0000.
